mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//   MEM/WB pipeline register plus writeback select for the 5-stage MIPS core.
//   Captures MEM-stage results, forms the write value, and drives the register
//   file write port (we/waddr/wdata) one cycle after MEM.
//   Also exports WB-stage forwarding info and a 32-bit retired-instruction counter.
// PARAMETERS
//   DATA_W   32  datapath / register width
//   ADDR_W   5   register address width (32 GPRs, $0 hard-wired to zero)
//   CNT_W    32  retired-instruction counter width
// PORTS
//   clk            in   1       core clock, all state on rising edge
//   rst_n          in   1       asynchronous active-low reset
//   stall          in   1       hold WB register contents
//   flush          in   1       replace captured entry with a bubble
//   mem_valid      in   1       MEM stage holds a real instruction
//   mem_reg_we     in   1       instruction writes a GPR
//   mem_waddr      in   ADDR_W  destination GPR
//   mem_is_load    in   1       1: write value is load data, 0: ALU result
//   mem_alu_result in   DATA_W  ALU result; low 2 bits are byte offset for loads
//   mem_rdata      in   DATA_W  raw word from data memory
//   mem_size       in   2       00 byte, 01 half, 10 word (11 treated as word)
//   mem_unsigned   in   1       1: zero-extend sub-word load, 0: sign-extend
//   wb_valid       out  1       WB register holds a real instruction
//   wb_we          out  1       register file write enable
//   wb_waddr       out  ADDR_W  register file write address
//   wb_wdata       out  DATA_W  register file write data
//   retired        out  CNT_W   count of instructions retired
// BEHAVIOUR
//   - Reset (async, rst_n=0): wb_valid=0, all captured fields=0, retired=0;
//     hence wb_we=0, wb_waddr=0, wb_wdata=0. Reset mid-stall/flush wins.
//   - Capture priority per rising edge: flush > stall > normal.
//     flush: wb_valid<=0, reg_we<=0, other fields don't-care (hold is fine).
//     stall (no flush): all fields hold.
//     normal: all mem_* fields registered; wb_valid<=mem_valid.
//   - Latency: MEM inputs at edge N -> regfile write at edge N+1.
//   - wb_we = wb_valid & reg_we_q & (waddr_q != 0); waddr 0 never writes.
//   - wb_waddr = waddr_q whenever wb_valid, else 0.
//   - wb_wdata combinational from registered fields: is_load_q ? load_val : alu_q;
//     forced 0 when wb_we=0.
//   - While stalled with wb_we=1, write repeats each cycle (idempotent, allowed).
//   - retired increments by 1 on an edge where wb_valid=1 and stall=0
//     (instruction leaves WB); one count per instruction regardless of stall
//     length; flush does not block the increment of the departing entry.
//     Wraps 2^CNT_W-1 -> 0 silently.
//   - Bubbles (mem_valid=0) with mem_reg_we=1 must not write.
// CONFIGURATION
//   WB_LOAD_EXT_EN defined: load_val built from mem_rdata_q, big-endian lanes:
//     byte: offset 0->[31:24], 1->[23:16], 2->[15:8], 3->[7:0];
//     half: offset[1]=0->[31:16], 1->[15:0]; offset[0] ignored;
//     sign- or zero-extended per mem_unsigned; word/11: full word.
//   WB_LOAD_EXT_EN undefined: load_val = mem_rdata_q unchanged; mem_size,
//     mem_unsigned and offset ignored (extension done upstream).
// TESTING
//   1 rst_n=0 while wb_we=1 -> all outputs 0 immediately, retired=0.
//   2 ALU op waddr=8, alu=0x1234_5678, is_load=0 -> next cycle wb_we=1,
//     wb_waddr=8, wb_wdata=0x1234_5678, retired 0->1 on following edge.
//   3 waddr=0, reg_we=1, valid=1 -> wb_we=0, wb_wdata=0; retired still +1.
//   4 EXT_EN: rdata=0x80FF_7F01, byte off 0 signed -> 0xFFFF_FF80;
//     off 2 unsigned -> 0x0000_007F; half off 2 signed -> 0x0000_7F01;
//     half off 0 unsigned -> 0x0000_80FF. No EXT_EN -> 0x80FF_7F01 for all.
//   5 stall 3 cycles with valid entry -> outputs hold, retired +1 only once;
//     stall+flush together -> wb_valid=0 next cycle.
//   6 preload retired=0xFFFF_FFFF, retire one -> retired=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline register and writeback select. Captures the
//               MEM-stage result, forms the register file write value and
//               drives the regfile write port one cycle after MEM. Also
//               provides a retired-instruction counter.
// Config      : define WB_LOAD_EXT_EN to perform big-endian sub-word load
//               lane selection and sign/zero extension in this stage;
//               otherwise the memory word is written unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_reg_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic              mem_is_load,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;

  logic              valid_q;
  logic              reg_we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic              is_load_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  retired_q;
  logic [CNT_W-1:0]  retired_d;
  logic [DATA_W-1:0] load_val;
  logic              we_w;

`ifdef WB_LOAD_EXT_EN
  logic [1:0]        size_q;
  logic              unsigned_q;

  // Sub-word load control fields follow the same capture rules as the rest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
    end else if (!flush && !stall) begin
      size_q     <= mem_size;
      unsigned_q <= mem_unsigned;
    end
  end

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Big-endian lane pick and extension of the captured memory word
  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    load_val = rdata_q;
    case (alu_q[1:0])
      2'd0:    byte_sel = rdata_q[31:24];
      2'd1:    byte_sel = rdata_q[23:16];
      2'd2:    byte_sel = rdata_q[15:8];
      default: byte_sel = rdata_q[7:0];
    endcase
    half_sel = alu_q[1] ? rdata_q[15:0] : rdata_q[31:16];
    case (size_q)
      c_SIZE_BYTE: load_val = {{(DATA_W-8){byte_sel[7] & ~unsigned_q}}, byte_sel};
      c_SIZE_HALF: load_val = {{(DATA_W-16){half_sel[15] & ~unsigned_q}}, half_sel};
      default:     load_val = rdata_q;
    endcase
  end
`else
  // Extension is done upstream; size/signedness inputs have no effect here
  logic unused_load_ctrl;
  assign unused_load_ctrl = ^{mem_size, mem_unsigned};
  assign load_val = rdata_q;
`endif

  // Pipeline register: flush inserts a bubble, stall holds, otherwise capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      reg_we_q  <= 1'b0;
      waddr_q   <= '0;
      is_load_q <= 1'b0;
      alu_q     <= '0;
      rdata_q   <= '0;
    end else if (flush) begin
      valid_q  <= 1'b0;
      reg_we_q <= 1'b0;
    end else if (!stall) begin
      valid_q   <= mem_valid;
      reg_we_q  <= mem_reg_we;
      waddr_q   <= mem_waddr;
      is_load_q <= mem_is_load;
      alu_q     <= mem_alu_result;
      rdata_q   <= mem_rdata;
    end
  end

  // An instruction retires when it leaves WB; flush does not cancel that
  always_comb begin
    retired_d = retired_q;
    if (valid_q && !stall) begin
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Retired-instruction counter, wraps silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  // $0 is hard-wired to zero, so a write to address 0 is suppressed
  assign we_w     = valid_q & reg_we_q & (waddr_q != '0);
  assign wb_valid = valid_q;
  assign wb_we    = we_w;
  assign wb_waddr = valid_q ? waddr_q : '0;
  assign wb_wdata = we_w ? (is_load_q ? load_val : alu_q) : '0;
  assign retired  = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Directed self-checking bench for mem_wb_stage. A second
//               instance with a 4-bit counter exercises counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_reg_we;
  logic [4:0]  mem_waddr;
  logic        mem_is_load;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [31:0] retired;
  logic        s_valid;
  logic        s_we;
  logic [4:0]  s_waddr;
  logic [31:0] s_wdata;
  logic [3:0]  s_retired;

  int checks;
  int errors;
  int exp_ret;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_we(mem_reg_we), .mem_waddr(mem_waddr),
    .mem_is_load(mem_is_load), .mem_alu_result(mem_alu_result),
    .mem_rdata(mem_rdata), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .retired(retired)
  );

  mem_wb_stage #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_we(mem_reg_we), .mem_waddr(mem_waddr),
    .mem_is_load(mem_is_load), .mem_alu_result(mem_alu_result),
    .mem_rdata(mem_rdata), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .wb_valid(s_valid), .wb_we(s_we), .wb_waddr(s_waddr),
    .wb_wdata(s_wdata), .retired(s_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; flush = 0; mem_valid = 0; mem_reg_we = 0; mem_waddr = 0;
    mem_is_load = 0; mem_alu_result = 0; mem_rdata = 0; mem_size = 0; mem_unsigned = 0;
  endtask

  task automatic drive_alu(input logic [4:0] a, input logic [31:0] v);
    mem_valid = 1; mem_reg_we = 1; mem_waddr = a; mem_is_load = 0;
    mem_alu_result = v; mem_rdata = 32'h0BAD_0BAD; mem_size = 2'b10; mem_unsigned = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #2;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", wb_valid); end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired got %0h exp 0", retired); end
    tick();
    rst_n = 1;
    drive_alu(5'd3, 32'hCAFE_F00D);
    tick();
    checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL pre_reset_we got %0h exp 1", wb_we); end
    #2 rst_n = 0;
    #1;
    checks++; if ({wb_valid, wb_we, wb_waddr} !== 7'd0) begin errors++; $display("FAIL async_reset_ctl got %0h exp 0", {wb_valid, wb_we, wb_waddr}); end
    checks++; if (wb_wdata !== 32'd0) begin errors++; $display("FAIL async_reset_wdata got %0h exp 0", wb_wdata); end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL async_reset_retired got %0h exp 0", retired); end
    idle();
    @(negedge clk);
    rst_n = 1;
    exp_ret = 0;
  endtask

  task automatic test_alu();
    drive_alu(5'd8, 32'h1234_5678);
    tick();
    checks++; if ({wb_valid, wb_we, wb_waddr} !== {1'b1, 1'b1, 5'd8}) begin errors++; $display("FAIL alu_ctl got %0h exp %0h", {wb_valid, wb_we, wb_waddr}, {1'b1, 1'b1, 5'd8}); end
    checks++; if (wb_wdata !== 32'h1234_5678) begin errors++; $display("FAIL alu_wdata got %0h exp 12345678", wb_wdata); end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL alu_retired_pre got %0d exp 0", retired); end
    idle();
    tick();
    exp_ret = 1;
    checks++; if (retired !== 32'd1) begin errors++; $display("FAIL alu_retired_post got %0d exp 1", retired); end
    checks++; if ({wb_valid, wb_we, wb_waddr, wb_wdata} !== 39'd0) begin errors++; $display("FAIL alu_drain got %0h exp 0", {wb_valid, wb_we, wb_waddr, wb_wdata}); end
  endtask

  task automatic test_zero_reg();
    drive_alu(5'd0, 32'hDEAD_BEEF);
    tick();
    checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin errors++; $display("FAIL r0_we got v=%0h we=%0h exp v=1 we=0", wb_valid, wb_we); end
    checks++; if (wb_wdata !== 32'd0) begin errors++; $display("FAIL r0_wdata got %0h exp 0", wb_wdata); end
    idle();
    tick();
    exp_ret = 2;
    checks++; if (retired !== 32'd2) begin errors++; $display("FAIL r0_retired got %0d exp 2", retired); end
    // Bubble that still claims a register write
    mem_valid = 0; mem_reg_we = 1; mem_waddr = 5'd5; mem_alu_result = 32'h5555_5555;
    tick();
    checks++; if ({wb_valid, wb_we, wb_waddr, wb_wdata} !== 39'd0) begin errors++; $display("FAIL bubble_write got %0h exp 0", {wb_valid, wb_we, wb_waddr, wb_wdata}); end
    idle();
    tick();
    checks++; if (retired !== 32'd2) begin errors++; $display("FAIL bubble_retired got %0d exp 2", retired); end
  endtask

  task automatic do_load(input string nm, input logic [1:0] sz, input logic uns,
                         input logic [1:0] off, input logic [31:0] exp_ext);
    logic [31:0] exp_v;
`ifdef WB_LOAD_EXT_EN
    exp_v = exp_ext;
`else
    exp_v = 32'h80FF_7F01;
`endif
    mem_valid = 1; mem_reg_we = 1; mem_waddr = 5'd9; mem_is_load = 1;
    mem_alu_result = {30'h0400_0000, off}; mem_rdata = 32'h80FF_7F01;
    mem_size = sz; mem_unsigned = uns;
    tick();
    checks++; if (wb_we !== 1'b1 || wb_wdata !== exp_v) begin errors++; $display("FAIL load_%s got we=%0h data=%08h exp we=1 data=%08h", nm, wb_we, wb_wdata, exp_v); end
    idle();
    tick();
    exp_ret++;
  endtask

  task automatic test_load();
    do_load("b0s", 2'b00, 1'b0, 2'd0, 32'hFFFF_FF80);
    do_load("b2u", 2'b00, 1'b1, 2'd2, 32'h0000_007F);
    do_load("b1s", 2'b00, 1'b0, 2'd1, 32'hFFFF_FFFF);
    do_load("h2s", 2'b01, 1'b0, 2'd2, 32'h0000_7F01);
    do_load("h0u", 2'b01, 1'b1, 2'd0, 32'h0000_80FF);
    do_load("h1s", 2'b01, 1'b0, 2'd1, 32'hFFFF_80FF);
    do_load("w",   2'b10, 1'b0, 2'd3, 32'h80FF_7F01);
    do_load("s11", 2'b11, 1'b1, 2'd1, 32'h80FF_7F01);
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL load_retired got %0d exp %0d", retired, exp_ret); end
  endtask

  task automatic test_stall_flush();
    drive_alu(5'd10, 32'hA5A5_A5A5);
    tick();
    stall = 1;
    drive_alu(5'd11, 32'h1111_1111);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 5'd10, 32'hA5A5_A5A5}) begin errors++; $display("FAIL stall_hold%0d got we=%0h a=%0d d=%08h exp we=1 a=10 d=a5a5a5a5", i, wb_we, wb_waddr, wb_wdata); end
      checks++; if (retired !== exp_ret) begin errors++; $display("FAIL stall_retired%0d got %0d exp %0d", i, retired, exp_ret); end
    end
    idle();
    tick();
    exp_ret++;
    checks++; if (retired !== exp_ret || wb_valid !== 1'b0) begin errors++; $display("FAIL stall_release got r=%0d v=%0h exp r=%0d v=0", retired, wb_valid, exp_ret); end
    // Stall and flush together: entry is dropped and not counted
    drive_alu(5'd12, 32'h0000_000C);
    tick();
    stall = 1; flush = 1;
    tick();
    checks++; if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_wdata !== 32'd0) begin errors++; $display("FAIL stall_flush got v=%0h we=%0h d=%08h exp 0", wb_valid, wb_we, wb_wdata); end
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL stall_flush_retired got %0d exp %0d", retired, exp_ret); end
    // Flush alone: the departing entry still counts, the incoming one is dropped
    idle();
    drive_alu(5'd13, 32'h0000_000D);
    tick();
    flush = 1;
    drive_alu(5'd14, 32'h0000_000E);
    tick();
    exp_ret++;
    checks++; if (wb_valid !== 1'b0 || wb_we !== 1'b0) begin errors++; $display("FAIL flush_bubble got v=%0h we=%0h exp 0", wb_valid, wb_we); end
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL flush_retired got %0d exp %0d", retired, exp_ret); end
    idle();
    tick();
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL flush_no_extra got %0d exp %0d", retired, exp_ret); end
  endtask

  task automatic test_back_to_back_wrap();
    logic [3:0] exp_small;
    exp_small = exp_ret[3:0];
    checks++; if (s_retired !== exp_small) begin errors++; $display("FAIL small_count got %0d exp %0d", s_retired, exp_small); end
    for (int i = 0; i < 20; i++) begin
      drive_alu(5'(i + 1), 32'(i + 100));
      tick();
      if (i > 0) exp_ret++;
      checks++; if (wb_wdata !== 32'(i + 100) || wb_waddr !== 5'(i + 1)) begin errors++; $display("FAIL b2b%0d got a=%0d d=%0d exp a=%0d d=%0d", i, wb_waddr, wb_wdata, i + 1, i + 100); end
      checks++; if (retired !== exp_ret) begin errors++; $display("FAIL b2b_retired%0d got %0d exp %0d", i, retired, exp_ret); end
      exp_small = exp_ret[3:0];
      checks++; if (s_retired !== exp_small) begin errors++; $display("FAIL wrap%0d got %0d exp %0d", i, s_retired, exp_small); end
    end
    idle();
    tick();
    exp_ret++;
    exp_small = exp_ret[3:0];
    checks++; if (retired !== exp_ret || s_retired !== exp_small) begin errors++; $display("FAIL wrap_final got %0d/%0d exp %0d/%0d", retired, s_retired, exp_ret, exp_small); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_ret = 0;
    rst_n = 0;
    idle();
    test_reset();
    test_alu();
    test_zero_reg();
    test_load();
    test_stall_flush();
    test_back_to_back_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
